data_sync_tx: RTL and testbench

DATA_SYNC_TX -- requirements
Module: data_sync_tx

---
 rtl/data_sync_tx_if.sv | 23 ++
 rtl/data_sync_tx.sv | 96 +++++++++
 tb/tb_data_sync_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sync_tx_if.sv
// Handshake and crossing-bus signals of the data_sync_tx source side.
// master = environment/producer side, slave = data_sync_tx itself.
interface data_sync_tx_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic                 src_valid;
  logic [BUS_WIDTH-1:0] src_data;
  logic                 src_ready;
  logic                 dst_ack;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 done_pulse;

  modport master (
    output src_valid, src_data, dst_ack,
    input  src_ready, unsync_bus, bus_enable, done_pulse
  );

  modport slave (
    input  src_valid, src_data, dst_ack,
    output src_ready, unsync_bus, bus_enable, done_pulse
  );
endinterface

// File: rtl/data_sync_tx.sv
// Source side of a 4-phase req/ack bus synchronizer: registers a word and a level
// request for the destination, completes once the synchronized ack has risen and fallen.
module data_sync_tx #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  data_sync_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] ack_sync_q;
  logic                  ack_sync;
  logic [BUS_WIDTH-1:0]  unsync_bus_q;
  logic                  bus_enable_q;
  logic                  bus_enable_d;
  logic                  done_pulse_q;
  logic                  done_pulse_d;
  logic                  load;
  logic                  src_ready;

  // dst_ack enters the first flop directly; nothing downstream sees it unsynchronized
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], bus.dst_ack};
    end
  end

  assign ack_sync  = ack_sync_q[NUM_STAGES-1];
  assign src_ready = (state_q == IDLE) && !ack_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bus_enable_q <= 1'b0;
      done_pulse_q <= 1'b0;
      unsync_bus_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_enable_q <= bus_enable_d;
      done_pulse_q <= done_pulse_d;
      if (load) begin
        unsync_bus_q <= bus.src_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_enable_d = bus_enable_q;
    done_pulse_d = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.src_valid && src_ready) begin
          load         = 1'b1;
          bus_enable_d = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        // request is held with no timeout until the destination acknowledges
        if (ack_sync) begin
          bus_enable_d = 1'b0;
          state_d      = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_sync) begin
          done_pulse_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        bus_enable_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  assign bus.src_ready  = src_ready;
  assign bus.unsync_bus = unsync_bus_q;
  assign bus.bus_enable = bus_enable_q;
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: directed handshake cases on an 8-bit/2-stage instance and a
// randomized crossing on a 16-bit/3-stage instance against a destination on its own clock.
module tb_data_sync_tx;

  localparam int unsigned NB = 20;

  logic clk  = 1'b0;
  logic dclk = 1'b0;
  logic reset_n_a;
  logic reset_n_b;

  always #5 clk  = ~clk;
  always #7 dclk = ~dclk;

  data_sync_tx_if #(.BUS_WIDTH(8))  ifa ();
  data_sync_tx_if #(.BUS_WIDTH(16)) ifb ();

  data_sync_tx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut_a (
    .clk     (clk),
    .reset_n (reset_n_a),
    .bus     (ifa)
  );

  data_sync_tx #(.NUM_STAGES(3), .BUS_WIDTH(16)) dut_b (
    .clk     (clk),
    .reset_n (reset_n_b),
    .bus     (ifb)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_a  = 0;
  int          done_b  = 0;
  logic        auto_a  = 1'b0;
  logic        auto_ack_a = 1'b0;
  logic        man_ack_a  = 1'b0;
  logic        prev_be_a  = 1'b0;
  logic [7:0]  held_a     = '0;
  logic [7:0]  expq_a[$];
  logic [15:0] expq_b[$];

  assign ifa.dst_ack = auto_a ? auto_ack_a : man_ack_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ifa.done_pulse) done_a++;
    if (ifb.done_pulse) done_b++;
  end

  // Destination model for instance A: acks each request, scores the word on request rise
  always @(posedge clk) begin
    #2;
    if (auto_a) begin
      if (ifa.bus_enable && !prev_be_a) begin
        check("a_sb_nonempty", 32'(expq_a.size() != 0), 1);
        if (expq_a.size() != 0) check("a_data", ifa.unsync_bus, expq_a.pop_front());
      end
      if (ifa.bus_enable && prev_be_a) check("a_stable", ifa.unsync_bus, held_a);
      auto_ack_a = ifa.bus_enable;
    end
    prev_be_a = ifa.bus_enable;
    held_a    = ifa.unsync_bus;
  end

  task automatic send_a(input logic [7:0] w);
    int t;
    expq_a.push_back(w);
    ifa.src_data  = w;
    ifa.src_valid = 1'b1;
    t = 0;
    while (t < 50 && !ifa.src_ready) begin step(); t++; end
    check("a_accept", ifa.src_ready, 1);
    step();
    ifa.src_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int t;
    t = 0;
    while (t < 100 && done_a < target) begin step(); t++; end
    check("a_done_count", done_a, target);
  endtask

  task automatic producer_b();
    int t;
    logic [15:0] w;
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(0, 3)) step();
      w = 16'($urandom);
      expq_b.push_back(w);
      ifb.src_data  = w;
      ifb.src_valid = 1'b1;
      t = 0;
      while (t < 400 && !ifb.src_ready) begin step(); t++; end
      check("b_accept", ifb.src_ready, 1);
      step();
      ifb.src_valid = 1'b0;
    end
  endtask

  task automatic consumer_b();
    int t;
    for (int i = 0; i < NB; i++) begin
      t = 0;
      while (t < 2000 && !ifb.bus_enable) begin @(posedge dclk); #1; t++; end
      check("b_req", ifb.bus_enable, 1);
      repeat ($urandom_range(0, 4)) begin @(posedge dclk); #1; end
      check("b_sb_nonempty", 32'(expq_b.size() != 0), 1);
      if (expq_b.size() != 0) check("b_data", ifb.unsync_bus, expq_b.pop_front());
      ifb.dst_ack = 1'b1;
      t = 0;
      while (t < 2000 && ifb.bus_enable) begin @(posedge dclk); #1; t++; end
      check("b_release", ifb.bus_enable, 0);
      repeat ($urandom_range(0, 4)) begin @(posedge dclk); #1; end
      ifb.dst_ack = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    int d0;
    logic rdy_seen;
    logic done_seen;

    ifa.src_valid = 1'b0;
    ifa.src_data  = '0;
    ifb.src_valid = 1'b0;
    ifb.src_data  = '0;
    ifb.dst_ack   = 1'b0;
    reset_n_a     = 1'b0;
    reset_n_b     = 1'b0;
    repeat (3) step();
    check("rst_be",    ifa.bus_enable, 0);
    check("rst_done",  ifa.done_pulse, 0);
    check("rst_bus",   ifa.unsync_bus, 0);
    check("rst_ready", ifa.src_ready, 1);
    check("rst_b_be",  ifb.bus_enable, 0);
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    step();

    // Single A5 transfer, ack raised the cycle after the request rises
    ifa.src_data  = 8'hA5;
    ifa.src_valid = 1'b1;
    step();
    ifa.src_valid = 1'b0;
    check("acc_bus", ifa.unsync_bus, 8'hA5);
    man_ack_a = 1'b1;
    cnt = 0; rdy_seen = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 20 && ifa.bus_enable; i++) begin
      cnt++;
      rdy_seen  = rdy_seen | ifa.src_ready;
      done_seen = done_seen | ifa.done_pulse;
      step();
    end
    check("req_width",  cnt, 3);
    check("req_ready",  rdy_seen, 0);
    check("req_done",   done_seen, 0);
    check("wl_ready",   ifa.src_ready, 0);
    check("wl_bus",     ifa.unsync_bus, 8'hA5);

    man_ack_a = 1'b0;
    n = 0;
    while (n < 20 && !ifa.done_pulse) begin step(); n++; end
    check("done_latency", n, 3);
    check("done_ready",   ifa.src_ready, 1);
    step();
    check("done_width",   ifa.done_pulse, 0);
    check("post_ready",   ifa.src_ready, 1);
    check("done_once",    done_a, 1);

    // Back-to-back with src_valid held high
    auto_a = 1'b1;
    ifa.src_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      ifa.src_data = 8'(w + 1);
      expq_a.push_back(8'(w + 1));
      n = 0;
      while (n < 50 && !ifa.src_ready) begin step(); n++; end
      check("b2b_accept", ifa.src_ready, 1);
      if (w > 0) check("b2b_gap", ifa.done_pulse, 1);
      step();
    end
    ifa.src_valid = 1'b0;
    wait_done_a(4);
    check("b2b_sb_empty", expq_a.size(), 0);

    // Stale ack out of reset; src_valid raised once the ack has reached the sync output
    auto_a    = 1'b0;
    man_ack_a = 1'b1;
    ifa.src_data = 8'h3C;
    reset_n_a = 1'b0;
    step();
    reset_n_a = 1'b1;
    repeat (2) step();
    ifa.src_valid = 1'b1;
    d0 = done_a;
    for (int i = 0; i < 4; i++) begin
      check("stale_ready", ifa.src_ready, 0);
      check("stale_be",    ifa.bus_enable, 0);
      step();
    end
    man_ack_a = 1'b0;
    n = 0;
    while (n < 20 && !ifa.src_ready) begin step(); n++; end
    check("stale_release", n, 2);
    check("stale_done",    done_a, d0);
    step();
    ifa.src_valid = 1'b0;
    check("stale_acc_be",  ifa.bus_enable, 1);
    check("stale_acc_bus", ifa.unsync_bus, 8'h3C);
    repeat (2) step();
    check("req_hold", ifa.bus_enable, 1);

    // Asynchronous reset pulse while in REQ
    #2 reset_n_a = 1'b0;
    #1;
    check("arst_be",   ifa.bus_enable, 0);
    check("arst_done", ifa.done_pulse, 0);
    check("arst_bus",  ifa.unsync_bus, 0);
    #2 reset_n_a = 1'b1;
    repeat (3) step();
    check("arst_no_done", done_a, d0);
    auto_a = 1'b1;
    send_a(8'h9E);
    wait_done_a(d0 + 1);
    check("arst_sb_empty", expq_a.size(), 0);
    auto_a = 1'b0;

    // Randomized crossing on the 16-bit / 3-stage instance
    fork
      producer_b();
      consumer_b();
    join
    n = 0;
    while (n < 100 && done_b < int'(NB)) begin step(); n++; end
    check("b_done_count", done_b, NB);
    check("b_sb_empty",   expq_b.size(), 0);
    repeat (5) step();
    check("b_done_final", done_b, NB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
